// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issue-side sequencer for the 16-bit ALU.
// It accepts one register-operation request per valid/ready handshake and
// reads both operands from the internal register file. It drives the ALU
// operand and operator inputs, then pulses alu_latch. It captures the ALU
// result and flags, writes the result back, and pulses done.
// The sequence is IDLE -> SETUP -> LATCH -> WB, one clock per state, so the
// block issues one op every 4 clocks.
// Optional build macro ALU_SEQ_DBG_EN adds a combinational register-file
// read port (dbg_addr / dbg_data).
module alu_issue_seq #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [AW-1:0] req_dst,
    input  logic [AW-1:0] req_src,
    input  logic          req_imm_en,
    input  logic [15:0]   req_imm,
    output logic [15:0]   alu_value1,
    output logic [15:0]   alu_value2,
    output logic [3:0]    alu_operator,
    output logic          alu_latch,
    input  logic [15:0]   alu_result,
    input  logic [3:0]    alu_flags,
    output logic [3:0]    flags_q,
    output logic          done
`ifdef ALU_SEQ_DBG_EN
    ,
    input  logic [AW-1:0] dbg_addr,
    output logic [15:0]   dbg_data
`endif
);

    // Compare only sets flags; every other code, including unknown ones,
    // writes back whatever the ALU produced.
    localparam logic [3:0] OP_CMP = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_LATCH,
        S_WB
    } state_t;

    state_t        state;
    logic [15:0]   regs [NREGS];
    logic [AW-1:0] dst_q;

    // Sequencer FSM.
    // It also owns the register file and every registered output, because
    // operand reads and the writeback are both tied to state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            req_ready    <= 1'b1;
            alu_latch    <= 1'b0;
            done         <= 1'b0;
            flags_q      <= '0;
            alu_value1   <= '0;
            alu_value2   <= '0;
            alu_operator <= '0;
            dst_q        <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        // Operands are read from the register file on the accept
                        // edge. They then hold until the next request is accepted.
                        // When dst==src, both operands see the same pre-op value.
                        req_ready    <= 1'b0;
                        dst_q        <= req_dst;
                        alu_operator <= req_op;
                        alu_value1   <= regs[req_dst];
                        alu_value2   <= req_imm_en ? req_imm : regs[req_src];
                        state        <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    alu_latch <= 1'b1;
                    state     <= S_LATCH;
                end
                S_LATCH: begin
                    alu_latch <= 1'b0;
                    flags_q   <= alu_flags;
                    if (alu_operator != OP_CMP) begin
                        regs[dst_q] <= alu_result;
                    end
                    done  <= 1'b1;
                    state <= S_WB;
                end
                S_WB: begin
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_DBG_EN
    // Debug read port.
    // It shows the register contents as currently stored. A write landing on
    // the same edge only becomes visible after that edge.
    always_comb begin
        dbg_data = regs[dbg_addr];
    end
`endif

endmodule
